// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcode, PSW bit index and issue-FSM state constants
package alu_pkg;

    typedef logic [1:0] issue_state_t;

    localparam issue_state_t ST_IDLE = 2'd0;
    localparam issue_state_t ST_WAIT = 2'd1;
    localparam issue_state_t ST_RESP = 2'd2;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_NOT = 4'b1000;

    localparam int PSW_N = 3;
    localparam int PSW_Z = 2;
    localparam int PSW_C = 1;
    localparam int PSW_V = 0;

endpackage

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issues one op to a combinational ALU, waits the settle time, returns result/psw
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int OPC_W      = 4,
    parameter int PSW_W      = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_opA,
    input  logic [DATA_W-1:0] req_opB,
    input  logic [OPC_W-1:0]  req_opcode,
    input  logic              req_setf,
    output logic [DATA_W-1:0] alu_operandA,
    output logic [DATA_W-1:0] alu_operandB,
    output logic [OPC_W-1:0]  alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [PSW_W-1:0]  alu_psw,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [PSW_W-1:0]  rsp_psw,
    output logic [PSW_W-1:0]  psw_reg,
    output logic              busy
);

    if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
        $error("alu_issue_ctrl: SETTLE_CYC must be in 1..15");
    end

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

    issue_state_t      state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic [OPC_W-1:0]  opc_q, opc_d;
    logic              setf_q, setf_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [PSW_W-1:0]  rsp_psw_q, rsp_psw_d;
    logic [PSW_W-1:0]  psw_reg_q, psw_reg_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        opc_d     = opc_q;
        setf_d    = setf_q;
        res_d     = res_q;
        rsp_psw_d = rsp_psw_q;
        psw_reg_d = psw_reg_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_a_d  = req_opA;
                    op_b_d  = req_opB;
                    opc_d   = req_opcode;
                    setf_d  = req_setf;
                    cnt_d   = SETTLE_LD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // cnt==1 marks the edge SETTLE_CYC cycles after operands were driven
                if (cnt_q == 4'd1) begin
                    res_d     = alu_result;
                    rsp_psw_d = alu_psw;
                    if (setf_q) begin
                        psw_reg_d = alu_psw;
                    end
                    cnt_d   = 4'd0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            opc_q     <= '0;
            setf_q    <= 1'b0;
            res_q     <= '0;
            rsp_psw_q <= '0;
            psw_reg_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            opc_q     <= opc_d;
            setf_q    <= setf_d;
            res_q     <= res_d;
            rsp_psw_q <= rsp_psw_d;
            psw_reg_q <= psw_reg_d;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign rsp_valid    = (state_q == ST_RESP);
    assign alu_operandA = op_a_q;
    assign alu_operandB = op_b_q;
    assign alu_opcode   = opc_q;
    assign rsp_result   = res_q;
    assign rsp_psw      = rsp_psw_q;
    assign psw_reg      = psw_reg_q;

endmodule
